// File: rtl/prm_pkg.sv
// Shared types and defaults for the PRM edge-mask accumulation pipeline.
package prm_pkg;

    localparam int unsigned PRM_NUM_EDGES = 512;
    localparam int unsigned PRM_CHUNK     = 32;

    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_COUNT = 2'd1,
        ST_HOLD  = 2'd2
    } prm_state_e;

    // Width able to hold any blocked-edge count from 0 to n inclusive.
    function automatic int unsigned prm_bcnt_w(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/prm_popcnt_chunk.sv
// Combinational population count of one CHUNK-bit slice of the accumulated mask.
module prm_popcnt_chunk #(
    parameter  int unsigned CHUNK = 32,
    localparam int unsigned CW    = $clog2(CHUNK + 1)
) (
    input  logic [CHUNK-1:0] i_bits,
    output logic [CW-1:0]    o_cnt
);

    always_comb begin
        o_cnt = '0;
        for (int i = 0; i < CHUNK; i++) begin
            o_cnt = o_cnt + CW'(i_bits[i]);
        end
    end

endmodule

// File: rtl/prm_edge_mask_accum.sv
// OR-accumulates per-voxel edge masks over a frame, counts blocked edges one
// chunk per cycle, then hands the free-edge vector to the planner.
module prm_edge_mask_accum
    import prm_pkg::*;
#(
    parameter int unsigned NUM_EDGES = PRM_NUM_EDGES,
    parameter int unsigned CHUNK     = PRM_CHUNK,
    parameter int unsigned VCNT_W    = 16
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [NUM_EDGES-1:0]                in_mask,
    input  logic                                in_last,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [NUM_EDGES-1:0]                out_free,
    output logic [prm_bcnt_w(NUM_EDGES)-1:0]    out_blocked_cnt,
    output logic [VCNT_W-1:0]                   out_voxel_cnt,
    output logic                                busy
);

    localparam int unsigned BCNT_W = prm_bcnt_w(NUM_EDGES);
    localparam int unsigned NCHUNK = NUM_EDGES / CHUNK;
    localparam int unsigned IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int unsigned PC_W   = $clog2(CHUNK + 1);

    prm_state_e              r_state;
    logic [NUM_EDGES-1:0]    r_acc;
    logic [VCNT_W-1:0]       r_vcnt;
    logic [BCNT_W-1:0]       r_bcnt;
    logic [IDX_W-1:0]        r_idx;

    logic [NCHUNK-1:0][CHUNK-1:0] w_acc_chunks;
    logic [CHUNK-1:0]             w_chunk;
    logic [PC_W-1:0]              w_pc;

    // View the accumulator as an array of chunks so idx selects one directly.
    assign w_acc_chunks = r_acc;
    assign w_chunk      = w_acc_chunks[r_idx];

    prm_popcnt_chunk #(
        .CHUNK (CHUNK)
    ) u_popcnt (
        .i_bits (w_chunk),
        .o_cnt  (w_pc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_ACCUM;
            r_acc   <= '0;
            r_vcnt  <= '0;
            r_bcnt  <= '0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                ST_ACCUM: begin
                    if (in_valid) begin
                        r_acc <= r_acc | in_mask;
                        if (r_vcnt != '1) begin
                            r_vcnt <= r_vcnt + VCNT_W'(1);
                        end
                        if (in_last) begin
                            r_state <= ST_COUNT;
                            r_idx   <= '0;
                            r_bcnt  <= '0;
                        end
                    end
                end
                ST_COUNT: begin
                    r_bcnt <= r_bcnt + BCNT_W'(w_pc);
                    r_idx  <= r_idx + IDX_W'(1);
                    if (r_idx == IDX_W'(NCHUNK - 1)) begin
                        r_state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        r_state <= ST_ACCUM;
                        r_acc   <= '0;
                        r_vcnt  <= '0;
                        r_bcnt  <= '0;
                        r_idx   <= '0;
                    end
                end
                default: r_state <= ST_ACCUM;
            endcase
        end
    end

    // Handshake signals decode only the state register; no input-to-output paths.
    assign in_ready        = (r_state == ST_ACCUM);
    assign out_valid       = (r_state == ST_HOLD);
    assign busy            = (r_state != ST_ACCUM);
    assign out_free        = ~r_acc;
    assign out_blocked_cnt = r_bcnt;
    assign out_voxel_cnt   = r_vcnt;

endmodule

// File: tb/tb_prm_edge_mask_accum.sv
// Self-checking bench for prm_edge_mask_accum against a frame-level reference model.
module tb_prm_edge_mask_accum;

    localparam int unsigned NE = 512;
    localparam int unsigned CH = 32;
    localparam int unsigned VW = 16;
    localparam int unsigned BW = $clog2(NE + 1);
    localparam int unsigned LAT = NE / CH;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [NE-1:0] in_mask;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [NE-1:0] out_free;
    logic [BW-1:0] out_blocked_cnt;
    logic [VW-1:0] out_voxel_cnt;
    logic          busy;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: frame OR of accepted masks and saturating beat count.
    logic [NE-1:0] m_acc;
    int            m_vcnt;

    prm_edge_mask_accum #(.NUM_EDGES(NE), .CHUNK(CH), .VCNT_W(VW)) dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_mask         (in_mask),
        .in_last         (in_last),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_free        (out_free),
        .out_blocked_cnt (out_blocked_cnt),
        .out_voxel_cnt   (out_voxel_cnt),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [NE-1:0] obs, input logic [NE-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NE-1:0] rand_dense();
        logic [NE-1:0] m;
        for (int k = 0; k < NE / 32; k++) m[k*32 +: 32] = $urandom;
        return m;
    endfunction

    function automatic logic [NE-1:0] rand_sparse();
        logic [NE-1:0] m;
        m = '0;
        for (int k = 0; k < 4; k++) m[$urandom_range(0, NE - 1)] = 1'b1;
        return m;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            in_valid = 1'b0;
            in_mask  = rand_dense();
            in_last  = 1'(($urandom) & 1);
            @(negedge clk);
        end
    endtask

    task automatic beat(input logic [NE-1:0] mask, input logic last);
        chk("in_ready_before_beat", NE'(in_ready), NE'(1));
        in_valid = 1'b1;
        in_mask  = mask;
        in_last  = last;
        @(negedge clk);
        in_valid = 1'b0;
        in_mask  = rand_dense();
        in_last  = 1'(($urandom) & 1);
        m_acc = m_acc | mask;
        if (m_vcnt < 65535) m_vcnt++;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_free"},    out_free, ~m_acc);
        chk({tag, "_blocked"}, NE'(out_blocked_cnt), NE'($countones(m_acc)));
        chk({tag, "_voxels"},  NE'(out_voxel_cnt), NE'(m_vcnt));
        chk({tag, "_valid"},   NE'(out_valid), NE'(1));
        chk({tag, "_inready"}, NE'(in_ready), NE'(0));
        chk({tag, "_busy"},    NE'(busy), NE'(1));
    endtask

    // Called at the negedge right after the last beat's accept edge.
    task automatic wait_result(input string tag);
        int n;
        n = 0;
        while (out_valid !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, NE'(n), NE'(LAT));
        check_outputs(tag);
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        m_acc  = '0;
        m_vcnt = 0;
        chk({tag, "_post_valid"},   NE'(out_valid), NE'(0));
        chk({tag, "_post_inready"}, NE'(in_ready), NE'(1));
        chk({tag, "_post_free"},    out_free, {NE{1'b1}});
        chk({tag, "_post_blocked"}, NE'(out_blocked_cnt), NE'(0));
        chk({tag, "_post_voxels"},  NE'(out_voxel_cnt), NE'(0));
    endtask

    initial begin
        logic [NE-1:0] mk;
        int            nb;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_mask   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        m_acc     = '0;
        m_vcnt    = 0;

        // Reset state
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_inready", NE'(in_ready), NE'(1));
        chk("rst_valid",   NE'(out_valid), NE'(0));
        chk("rst_busy",    NE'(busy), NE'(0));
        chk("rst_free",    out_free, {NE{1'b1}});
        chk("rst_blocked", NE'(out_blocked_cnt), NE'(0));
        chk("rst_voxels",  NE'(out_voxel_cnt), NE'(0));

        // Single empty beat
        beat('0, 1'b1);
        wait_result("empty");
        handshake("empty");

        // Overlapping masks; out_ready held high during accumulation must be harmless
        out_ready = 1'b1;
        mk = '0; mk[0] = 1'b1; mk[5] = 1'b1;
        beat(mk, 1'b0);
        mk = '0; mk[5] = 1'b1; mk[511] = 1'b1;
        beat(mk, 1'b0);
        out_ready = 1'b0;
        mk = '0; mk[100] = 1'b1;
        beat(mk, 1'b1);
        wait_result("overlap");
        chk("overlap_blocked_const", NE'(out_blocked_cnt), NE'(4));
        chk("overlap_voxels_const",  NE'(out_voxel_cnt), NE'(3));
        handshake("overlap");

        // Random frames with input gaps and output backpressure
        for (int f = 0; f < 4; f++) begin
            nb = $urandom_range(1, 8);
            for (int b = 0; b < nb; b++) begin
                idle($urandom_range(0, 3));
                beat(((f & 1) != 0) ? rand_dense() : rand_sparse(), 1'(b == nb - 1));
            end
            wait_result("rand");
            for (int c = 0; c < 10; c++) begin
                in_valid = 1'b1;
                in_mask  = rand_dense();
                in_last  = 1'b1;
                @(negedge clk);
                check_outputs("hold");
            end
            in_valid = 1'b0;
            handshake("rand");
        end

        // Next frame must start from a clean accumulator
        mk = '0; mk[300] = 1'b1;
        beat(mk, 1'b1);
        wait_result("clean");
        chk("clean_blocked_const", NE'(out_blocked_cnt), NE'(1));
        handshake("clean");

        // Saturating voxel counter
        mk = '0; mk[7] = 1'b1;
        in_valid = 1'b1;
        in_mask  = mk;
        in_last  = 1'b0;
        repeat (65540) @(negedge clk);
        in_last = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        m_acc  = mk;
        m_vcnt = 65535;
        wait_result("sat");
        chk("sat_voxels_const",  NE'(out_voxel_cnt), NE'(16'hFFFF));
        chk("sat_blocked_const", NE'(out_blocked_cnt), NE'(1));
        handshake("sat");

        // Asynchronous reset during COUNT discards the frame
        beat(rand_dense(), 1'b1);
        repeat (5) @(negedge clk);
        chk("midcount_busy", NE'(busy), NE'(1));
        #2 rst = 1'b1;
        #1;
        chk("arst_inready", NE'(in_ready), NE'(1));
        chk("arst_valid",   NE'(out_valid), NE'(0));
        chk("arst_busy",    NE'(busy), NE'(0));
        chk("arst_free",    out_free, {NE{1'b1}});
        chk("arst_blocked", NE'(out_blocked_cnt), NE'(0));
        chk("arst_voxels",  NE'(out_voxel_cnt), NE'(0));
        @(negedge clk);
        rst    = 1'b0;
        m_acc  = '0;
        m_vcnt = 0;
        @(negedge clk);
        beat({NE{1'b1}}, 1'b1);
        wait_result("full");
        chk("full_blocked_const", NE'(out_blocked_cnt), NE'(512));
        handshake("full");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
